// File: rtl/srt4_div_seq.sv
// rtl/srt4_div_seq.sv - radix-4 SRT divider iteration controller with on-the-fly quotient conversion
module srt4_div_seq #(
    parameter int ITERS = 14,
    parameter int CNT_W = 4,
    localparam int QW = 2 * ITERS
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          en,
    input  logic          start,
    input  logic          mul_n3,
    input  logic          mul_n2,
    input  logic          mul_n1,
    input  logic          mul_0,
    input  logic          mul_1,
    input  logic          mul_2,
    input  logic          mul_3,
    input  logic          rem_neg,
    input  logic          rem_zero,
    output logic          rem_load,
    output logic          rem_step,
    output logic [2:0]    dig,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quot,
    output logic          sticky,
    output logic          err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [QW-1:0]    q_r;
    logic [QW-1:0]    qm_r;

    logic [6:0]       mul_vec;
    logic [2:0]       dig_raw;
    logic             dig_ok;
    logic             step;
    logic [QW-1:0]    q4;
    logic [QW-1:0]    qm4;
    logic [QW-1:0]    dq;
    logic [QW-1:0]    q_nxt;
    logic [QW-1:0]    qm_nxt;

    assign mul_vec = {mul_3, mul_2, mul_1, mul_0, mul_n1, mul_n2, mul_n3};

    // Anything other than exactly one selector line is treated as a zero digit.
    always_comb begin
        dig_raw = 3'b000;
        dig_ok  = 1'b1;
        case (mul_vec)
            7'b0000001: dig_raw = 3'b101;
            7'b0000010: dig_raw = 3'b110;
            7'b0000100: dig_raw = 3'b111;
            7'b0001000: dig_raw = 3'b000;
            7'b0010000: dig_raw = 3'b001;
            7'b0100000: dig_raw = 3'b010;
            7'b1000000: dig_raw = 3'b011;
            default:    dig_ok  = 1'b0;
        endcase
    end

    assign step     = (state == S_ITER) && en;
    assign rem_step = step;
    assign dig      = step ? dig_raw : 3'b000;
    assign rem_load = (state == S_LOAD);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    assign q4  = {q_r[QW-3:0], 2'b00};
    assign qm4 = {qm_r[QW-3:0], 2'b00};
    assign dq  = {{(QW-3){dig_raw[2]}}, dig_raw};

    // Negative digits borrow from QM so no carry ever ripples through Q.
    always_comb begin
        q_nxt  = q4;
        qm_nxt = qm4 | QW'(3);
        if (dig_raw[2]) begin
            q_nxt  = qm4 + dq + QW'(4);
            qm_nxt = qm4 + dq + QW'(3);
        end else if (dig_raw != 3'b000) begin
            q_nxt  = q4 + dq;
            qm_nxt = q4 + dq - QW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            q_r    <= '0;
            qm_r   <= '1;
            quot   <= '0;
            sticky <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    q_r   <= '0;
                    qm_r  <= '1;
                    cnt   <= '0;
                    err   <= 1'b0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    if (en) begin
                        q_r  <= q_nxt;
                        qm_r <= qm_nxt;
                        cnt  <= cnt + 1'b1;
                        if (!dig_ok) err <= 1'b1;
                        if (cnt == CNT_W'(ITERS - 1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quot   <= rem_neg ? qm_r : q_r;
                    sticky <= ~rem_zero;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srt4_div_seq.sv
// tb/tb_srt4_div_seq.sv - self-checking bench for srt4_div_seq
module tb_srt4_div_seq;

    localparam int ITERS = 14;
    localparam int QW    = 2 * ITERS;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          en = 1'b1;
    logic          start = 1'b0;
    logic          rem_neg = 1'b0;
    logic          rem_zero = 1'b0;
    logic [6:0]    mul_vec;
    logic          mul_n3, mul_n2, mul_n1, mul_0, mul_1, mul_2, mul_3;
    logic          rem_load, rem_step, busy, done, sticky, err;
    logic [2:0]    dig;
    logic [QW-1:0] quot;

    assign {mul_3, mul_2, mul_1, mul_0, mul_n1, mul_n2, mul_n3} = mul_vec;

    srt4_div_seq #(.ITERS(ITERS), .CNT_W(4)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .start(start),
        .mul_n3(mul_n3), .mul_n2(mul_n2), .mul_n1(mul_n1), .mul_0(mul_0),
        .mul_1(mul_1), .mul_2(mul_2), .mul_3(mul_3),
        .rem_neg(rem_neg), .rem_zero(rem_zero),
        .rem_load(rem_load), .rem_step(rem_step), .dig(dig), .busy(busy),
        .done(done), .quot(quot), .sticky(sticky), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [6:0] codes [ITERS];

    typedef struct {
        string         name;
        int            d0;
        int            d1;
        int            fill;
        bit            neg;
        bit            zero;
        logic [QW-1:0] exp_quot;
        bit            exp_sticky;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] oh(input int d);
        logic [6:0] v;
        v = 7'd1 << (d + 3);
        return v;
    endfunction

    function automatic int dec(input logic [6:0] c);
        if ($countones(c) != 1) return 0;
        for (int i = 0; i < 7; i++) if (c[i]) return i - 3;
        return 0;
    endfunction

    // Quotient is the plain radix-4 weighted digit sum; a negative remainder takes one ulp off.
    function automatic logic [QW-1:0] model_quot(input bit neg);
        logic [QW-1:0] acc;
        acc = '0;
        for (int i = 0; i < ITERS; i++) acc = (acc << 2) + QW'(dec(codes[i]));
        return neg ? acc - QW'(1) : acc;
    endfunction

    function automatic bit model_err();
        for (int i = 0; i < ITERS; i++) if ($countones(codes[i]) != 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_op(input int stall_at, input int stall_len, input bit neg, input bit zero,
                          input bit pulse_start, output logic [QW-1:0] r_quot, output bit r_sticky,
                          output bit r_err, output int r_done_cyc, output int r_seq_bad);
        int k;
        bit en_c;
        bit exp_step;
        logic [2:0] exp_dig;
        logic [QW-1:0] part;
        logic [QW-1:0] part_m1;
        int last_iter;
        last_iter  = 15 + stall_len;
        r_done_cyc = -1;
        r_seq_bad  = 0;
        r_quot     = '0;
        r_sticky   = 1'b0;
        r_err      = 1'b0;
        part       = '0;
        rem_neg    = neg;
        rem_zero   = zero;
        for (int cyc = 0; cyc < 60; cyc++) begin
            start = (cyc == 0) || (pulse_start && (cyc == 6 || cyc == last_iter + 2));
            en_c  = !(cyc >= 2 + stall_at && cyc < 2 + stall_at + stall_len);
            if (cyc < 2 + stall_at) k = cyc - 2;
            else if (cyc < 2 + stall_at + stall_len) k = stall_at;
            else k = cyc - 2 - stall_len;
            en      = en_c;
            mul_vec = (k >= 0 && k < ITERS) ? codes[k] : oh(0);
            exp_step = (cyc >= 2 && cyc <= last_iter && en_c);
            exp_dig  = (exp_step && k >= 0 && k < ITERS) ? 3'(dec(codes[k])) : 3'b000;
            @(negedge clk);
            if (rem_step !== exp_step || dig !== exp_dig) r_seq_bad++;
            if (rem_load !== (cyc == 1)) r_seq_bad++;
            if (busy !== (cyc >= 1 && cyc <= last_iter + 2)) r_seq_bad++;
            if (done === 1'b1 && cyc != last_iter + 2) r_seq_bad++;
            if (cyc >= 2 && cyc <= last_iter) begin
                part_m1 = part - QW'(1);
                if (dut.q_r !== part || dut.qm_r !== part_m1) r_seq_bad++;
            end
            if (exp_step) part = (part << 2) + QW'(dec(codes[k]));
            if (done === 1'b1 && r_done_cyc < 0) begin
                r_done_cyc = cyc;
                r_quot     = quot;
                r_sticky   = sticky;
                r_err      = err;
            end
            @(posedge clk);
            #1;
            if (r_done_cyc >= 0 && cyc >= r_done_cyc + 1) break;
        end
        start = 1'b0;
        en    = 1'b1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < ITERS; i++) codes[i] = oh(int'($urandom_range(0, 6)) - 3);
    endtask

    vec_t          vecs [4];
    logic [QW-1:0] r_quot;
    logic [QW-1:0] exp_q;
    bit            r_sticky, r_err;
    int            r_done, r_bad;
    int            stall_len;
    int            done_seen;

    initial begin
        vecs[0] = '{"all_zero",  0,  0, 0, 1'b0, 1'b1, 28'h0000000, 1'b0};
        vecs[1] = '{"first_one", 1,  0, 0, 1'b0, 1'b0, 28'h4000000, 1'b1};
        vecs[2] = '{"one_mone",  1, -1, 0, 1'b1, 1'b0, 28'h2FFFFFF, 1'b1};
        vecs[3] = '{"all_three", 3,  3, 3, 1'b0, 1'b1, 28'hFFFFFFF, 1'b0};

        mul_vec = oh(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load", rem_load, 0);
        check("rst_step", rem_step, 0);
        check("rst_dig", dig, 0);
        check("rst_quot", quot, 0);
        check("rst_sticky", sticky, 0);
        check("rst_err", err, 0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            codes[0] = oh(vecs[v].d0);
            codes[1] = oh(vecs[v].d1);
            for (int i = 2; i < ITERS; i++) codes[i] = oh(vecs[v].fill);
            run_op(0, 0, vecs[v].neg, vecs[v].zero, 1'b0, r_quot, r_sticky, r_err, r_done, r_bad);
            check({vecs[v].name, "_quot"}, r_quot, vecs[v].exp_quot);
            check({vecs[v].name, "_sticky"}, r_sticky, vecs[v].exp_sticky);
            check({vecs[v].name, "_err"}, r_err, 0);
            check({vecs[v].name, "_done_cyc"}, r_done, 17);
            check({vecs[v].name, "_seq"}, r_bad, 0);
        end

        // Five-cycle stall mid-ITER with start pulses while busy and in DONE.
        fill_random();
        exp_q = model_quot(1'b1);
        run_op(4, 5, 1'b1, 1'b0, 1'b1, r_quot, r_sticky, r_err, r_done, r_bad);
        check("stall_quot", r_quot, exp_q);
        check("stall_done_cyc", r_done, 22);
        check("stall_seq", r_bad, 0);

        // Missing and doubled selector lines.
        fill_random();
        codes[3] = 7'b0000000;
        codes[5] = oh(1) | oh(2);
        exp_q = model_quot(1'b0);
        run_op(0, 0, 1'b0, 1'b0, 1'b0, r_quot, r_sticky, r_err, r_done, r_bad);
        check("bad_dig_quot", r_quot, exp_q);
        check("bad_dig_err", r_err, 1);
        check("bad_dig_seq", r_bad, 0);
        fill_random();
        run_op(0, 0, 1'b0, 1'b1, 1'b0, r_quot, r_sticky, r_err, r_done, r_bad);
        check("err_cleared", r_err, 0);

        for (int t = 0; t < 16; t++) begin
            fill_random();
            rem_neg   = 1'($urandom_range(0, 1));
            rem_zero  = 1'($urandom_range(0, 1));
            stall_len = int'($urandom_range(0, 3));
            exp_q = model_quot(rem_neg);
            run_op(int'($urandom_range(0, 13)), stall_len, rem_neg, rem_zero, 1'($urandom_range(0, 1)),
                   r_quot, r_sticky, r_err, r_done, r_bad);
            check($sformatf("rand%0d_quot", t), r_quot, exp_q);
            check($sformatf("rand%0d_sticky", t), r_sticky, !rem_zero);
            check($sformatf("rand%0d_err", t), r_err, model_err());
            check($sformatf("rand%0d_done_cyc", t), r_done, 17 + stall_len);
            check($sformatf("rand%0d_seq", t), r_bad, 0);
        end

        // Asynchronous reset at step 7 of an operation.
        for (int i = 0; i < ITERS; i++) codes[i] = oh(2);
        mul_vec = oh(2);
        en = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        n_rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_step", rem_step, 0);
        check("midrst_dig", dig, 0);
        check("midrst_quot", quot, 0);
        check("midrst_sticky", sticky, 0);
        check("midrst_err", err, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
